// File: rtl/pulse_serializer.sv
// rtl/pulse_serializer.sv - four-word pulse-width frame serializer
//
// Sends one frame per accepted start: a SYNC_CYCLES low preamble, then four
// high pulses whose lengths equal data3, data2, data1, data0, separated by
// GAP_CYCLES low gaps. Drives the pulse-width deserializer's serial input.
//
// Ports:
//   clk        system clock, all state updates on posedge
//   reset      synchronous, active-high reset
//   start      frame request, sampled only while ready=1
//   data3..0   words to send, latched on the accept edge (data3 goes first)
//   ready      high only while idle
//   ser_out    registered serial line, idles low
//   frame_done one-cycle pulse after the last pulse of a frame ends
//   zero_err   one-cycle pulse flagging a zero data word
//
// Optional feature macro: SER_ZERO_CLAMP_EN
//   defined   - zero words are sent as 1-cycle pulses, zero_err still pulses
//   undefined - a start carrying any zero word is rejected, zero_err pulses

`ifndef THRESHOLD
`define THRESHOLD 10
`endif

module pulse_serializer #(
    parameter int WIDTH       = 8,
    parameter int SYNC_CYCLES = `THRESHOLD + 2,
    parameter int GAP_CYCLES  = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data3,
    input  logic [WIDTH-1:0] data2,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data0,
    output logic             ready,
    output logic             ser_out,
    output logic             frame_done,
    output logic             zero_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        PULSE = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t                    state, state_n;
    logic [CNT_W-1:0]          cnt, cnt_n;
    logic [1:0]                idx, idx_n;
    logic [3:0][WIDTH-1:0]     hold, hold_n;
    logic                      frame_done_n;
    logic                      zero_err_n;
    logic                      any_zero;
    logic                      accept;
    logic [CNT_W-1:0]          cur_len_m1;

    // A zero word becomes a 1-cycle pulse; harmless when zeros are rejected.
    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] w);
        return (w == '0) ? WIDTH'(1) : w;
    endfunction

    assign any_zero   = (data3 == '0) || (data2 == '0) || (data1 == '0) || (data0 == '0);
    // Held words are never zero, so length-1 cannot wrap.
    assign cur_len_m1 = CNT_W'(hold[idx]) - CNT_W'(1);

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        idx_n        = idx;
        hold_n       = hold;
        frame_done_n = 1'b0;
        zero_err_n   = 1'b0;
        accept       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    zero_err_n = any_zero;
`ifdef SER_ZERO_CLAMP_EN
                    accept = 1'b1;
`else
                    accept = !any_zero;
`endif
                end
                if (accept) begin
                    state_n = SYNC;
                    // SYNC_CYCLES rather than length-1: ser_out follows the
                    // next state, so the preamble needs one extra count to
                    // land the first rising edge at accept+SYNC_CYCLES+1.
                    cnt_n   = CNT_W'(SYNC_CYCLES);
                    idx_n   = 2'd3;
                    hold_n  = {clamp(data3), clamp(data2), clamp(data1), clamp(data0)};
                end
            end
            SYNC: begin
                if (cnt == '0) begin
                    state_n = PULSE;
                    cnt_n   = cur_len_m1;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            PULSE: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else if (idx == 2'd0) begin
                    state_n      = IDLE;
                    frame_done_n = 1'b1;
                end else begin
                    state_n = GAP;
                    cnt_n   = CNT_W'(GAP_CYCLES - 1);
                    idx_n   = idx - 2'd1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_n = PULSE;
                    cnt_n   = cur_len_m1;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            hold       <= '0;
            ser_out    <= 1'b0;
            frame_done <= 1'b0;
            zero_err   <= 1'b0;
            ready      <= 1'b1;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            hold       <= hold_n;
            ser_out    <= (state_n == PULSE);
            frame_done <= frame_done_n;
            zero_err   <= zero_err_n;
            ready      <= (state_n == IDLE);
        end
    end

endmodule

// File: tb/tb_pulse_serializer.sv
// tb/tb_pulse_serializer.sv - self-checking bench for pulse_serializer

`ifndef THRESHOLD
`define THRESHOLD 10
`endif

module tb_pulse_serializer;

    localparam int S = `THRESHOLD + 2;
    localparam int G = 2;
    localparam int T = `THRESHOLD;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data3 = '0, data2 = '0, data1 = '0, data0 = '0;
    logic       ready, ser_out, frame_done, zero_err;

    int n_checks = 0;
    int n_errors = 0;
    int frame_id = 0;

    // Expected per-cycle outputs {ser_out, frame_done, ready, zero_err}
    logic [3:0] exp_q[$];

    pulse_serializer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .data3      (data3),
        .data2      (data2),
        .data1      (data1),
        .data0      (data0),
        .ready      (ready),
        .ser_out    (ser_out),
        .frame_done (frame_done),
        .zero_err   (zero_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic logic [3:0] obs();
        return {ser_out, frame_done, ready, zero_err};
    endfunction

    // Waveform model: a frame is a flat list of line levels built from the words.
    task automatic build(input int w3, input int w2, input int w1, input int w0);
        int  w[4];
        bit  anyz;
        w[0] = w3; w[1] = w2; w[2] = w1; w[3] = w0;
        anyz = (w3 == 0) || (w2 == 0) || (w1 == 0) || (w0 == 0);
        exp_q.delete();
`ifndef SER_ZERO_CLAMP_EN
        if (anyz) begin
            exp_q.push_back(4'b0011);
            return;
        end
`endif
        exp_q.push_back({3'b000, anyz});
        repeat (S) exp_q.push_back(4'b0000);
        for (int k = 0; k < 4; k++) begin
            repeat ((w[k] == 0) ? 1 : w[k]) exp_q.push_back(4'b1000);
            if (k < 3) repeat (G) exp_q.push_back(4'b0000);
        end
        exp_q.push_back(4'b0110);
    endtask

    task automatic send(input int w3, input int w2, input int w1, input int w0,
                        input bit noise, input int abort_at);
        build(w3, w2, w1, w0);
        frame_id++;
        data3 = 8'(w3); data2 = 8'(w2); data1 = 8'(w1); data0 = 8'(w0);
        start = 1'b1;
        @(posedge clk); @(negedge clk);
        for (int k = 0; k < exp_q.size(); k++) begin
            check($sformatf("f%0d_c%0d", frame_id, k), 32'(obs()), 32'(exp_q[k]));
            if (k == abort_at) begin
                reset = 1'b1;
                start = 1'b0;
                @(posedge clk); @(negedge clk);
                check($sformatf("f%0d_abort", frame_id), 32'(obs()), 32'h2);
                reset = 1'b0;
                return;
            end
            if (k == exp_q.size() - 1) break;
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                data3 = 8'd9; data2 = 8'd9; data1 = 8'd9; data0 = 8'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) begin
            @(posedge clk); @(negedge clk);
            check("idle", 32'(obs()), 32'h2);
        end
    endtask

    initial begin
        int w[4];
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", 32'(obs()), 32'h2);
        reset = 1'b0;
        idle(2);

        send(3, 5, 1, 7, 1'b0, -1);
        idle(3);

        send(2, 2, 2, 2, 1'b0, -1);
        send(2, 2, 2, 2, 1'b0, -1);
        idle(2);

        send(3, 5, 1, 7, 1'b1, -1);
        idle(2);

        send(3, 5, 1, 7, 1'b0, 1 + S + 3 + G + 2);
        idle(4);
        send(3, 5, 1, 7, 1'b0, -1);
        idle(2);

        send(0, 4, 4, 4, 1'b0, -1);
        idle(2);

        send(255, T + 1, 1, T, 1'b0, -1);
        idle(2);

        for (int f = 0; f < 15; f++) begin
            for (int j = 0; j < 4; j++)
                w[j] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 30));
            send(w[0], w[1], w[2], w[3], 1'($urandom_range(0, 1)), -1);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
